txn_done_return: RTL and testbench
==================================

Name: txn_done_return

Overview:
- Completion side of the TXN controller's outstanding-transaction accounting.
- Buffers read responses from the back end and hands them to the front end with a valid/ready handshake. Also absorbs back-end write acknowledgements.
- Converts every retired transaction into exactly one read_done or write_done pulse for the overflow-stopper counters.
- Delays a done pulse while the mapper is issuing the opposite request type, so that no pulse is dropped by the stopper's increment/decrement priority.

Parameters:
- DATA_W, 32, read response data width.
- ID_W, 8, read response tag width.
- RD_FIFO_DEPTH, 16, read response FIFO entries; power of two, at least 2.
- MAX_PEND, 32, maximum unissued done pulses held per type.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; block runs when 1 and clears when 0.
- rd_resp_valid  in  1  back-end read response valid.
- rd_resp_ready  out  1  FIFO can accept; equals not-full.
- rd_resp_data  in  DATA_W  read data.
- rd_resp_id  in  ID_W  read tag.
- wr_ack_valid  in  1  back-end write completion, one-cycle pulse per write.
- rsp_valid  out  1  front-end response valid.
- rsp_ready  in  1  front-end accepts response.
- rsp_data  out  DATA_W  head-of-FIFO data.
- rsp_id  out  ID_W  head-of-FIFO tag.
- mapper_valid  in  1  mapper is issuing a request this cycle (same signal the stopper sees).
- the_req_type  in  1  type of the issuing request; read/write encoding is from types_def.
- read_done  out  1  one pulse per retired read.
- write_done  out  1  one pulse per retired write.
- pend_overflow  out  1  sticky error flag, set when a pending counter saturates.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FIFO pointers cleared and count set to 0.
  - pend_rd and pend_wr set to 0; pend_overflow set to 0.
  - Resulting outputs: rsp_valid=0, rd_resp_ready=1, read_done=0, write_done=0.
  - A reset mid-operation discards buffered responses and pending dones; rsp_valid is 0 in the cycle after the reset edge.
- Read FIFO:
  - Write on rd_resp_valid && rd_resp_ready.
  - Pop on rsp_valid && rsp_ready.
  - rsp_valid = count != 0. rsp_data and rsp_id come from the head entry and stay stable while rsp_valid && !rsp_ready.
  - Latency: a response accepted at edge N gives rsp_valid=1 in cycle N+1. There is no combinational path from rd_resp_* to rsp_*.
  - Push and pop in the same cycle leave count unchanged. When full, the same-cycle pop still lets the push through only on the next cycle, because rd_resp_ready is registered-state based.
  - Pointers wrap modulo RD_FIFO_DEPTH; count width is clog2(RD_FIFO_DEPTH)+1.
- Pending done counters, each clog2(MAX_PEND)+1 bits wide:
  - rd_inc = front-end pop; wr_inc = wr_ack_valid.
  - Issue rules:
    - read_done = (pend_rd != 0) && (!mapper_valid || the_req_type==read).
    - write_done = (pend_wr != 0) && (!mapper_valid || the_req_type==write).
  - Both done outputs are combinational from registered counters and the two mapper inputs only.
  - Update: pend_x <= pend_x + inc_x - done_x. Increment and done in the same cycle is net zero.
  - Earliest done pulse: one cycle after the pop or ack.
  - When mapper_valid=0, both dones may pulse in the same cycle.
  - Saturation: if pend_x==MAX_PEND and inc_x && !done_x, the counter holds and pend_overflow is set until reset.
- Ordering: done pulses carry no identity. Response order equals back-end arrival order.

Optional Feature:
- Macro DONE_STATS_EN. When defined, adds two outputs: rd_retired_cnt and wr_retired_cnt, each 16 bits.
  - They increment on each read_done / write_done pulse and wrap at 0xFFFF→0.
  - Both cleared by reset.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then 3 read responses with ids 1,2,3 and rsp_ready=1, mapper_valid=0 → rsp ids 1,2,3 in order; three read_done pulses, each one cycle after its pop; write_done stays 0.
- Fill the FIFO with 16 responses while rsp_ready=0 → rd_resp_ready=0 after the 16th; raise rsp_ready → rd_resp_ready=1 after the first pop; all 16 delivered and no data lost.
- wr_ack_valid pulse while mapper_valid=1 with type=read for 4 cycles → write_done stays 0 for those 4 cycles and pulses once when mapper_valid drops.
- pend_rd=2 and pend_wr=1 with mapper_valid=0 → read_done and write_done both pulse in cycle 1; read_done alone pulses in cycle 2; both counters reach 0.
- Drive 33 write acks with mapper_valid=1 and type=read throughout → pend_wr saturates at 32, pend_overflow=1 and stays set until rst=0.
- rst=0 asserted with 5 responses buffered and pend_rd=3 → next cycle rsp_valid=0, read_done=0, rd_resp_ready=1; with DONE_STATS_EN, both stats counters read 0.

Source files
------------

// File: rtl/txn_done_return.sv
// Completion path for TXN accounting: read-response FIFO, write-ack absorption, and done-pulse issue.
// Optional retired-transaction counters are enabled by defining DONE_STATS_EN.
module txn_done_return #(
  parameter int DATA_W        = 32,
  parameter int ID_W          = 8,
  parameter int RD_FIFO_DEPTH = 16,
  parameter int MAX_PEND      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_resp_valid,
  output logic              rd_resp_ready,
  input  logic [DATA_W-1:0] rd_resp_data,
  input  logic [ID_W-1:0]   rd_resp_id,
  input  logic              wr_ack_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  input  logic              mapper_valid,
  input  logic              the_req_type,
  output logic              read_done,
  output logic              write_done,
  output logic              pend_overflow
`ifdef DONE_STATS_EN
  ,
  output logic [15:0]       rd_retired_cnt,
  output logic [15:0]       wr_retired_cnt
`endif
);

  localparam logic READ_TYPE  = 1'b0;
  localparam logic WRITE_TYPE = 1'b1;
  localparam int   PTR_W      = $clog2(RD_FIFO_DEPTH);
  localparam int   CNT_W      = PTR_W + 1;
  localparam int   PEND_W     = $clog2(MAX_PEND) + 1;

  logic [DATA_W-1:0] data_mem [RD_FIFO_DEPTH];
  logic [ID_W-1:0]   id_mem   [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PEND_W-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic              pend_overflow_q, pend_overflow_d;
  logic              push, pop;

  function automatic logic pend_sat(input logic [PEND_W-1:0] cur, input logic inc,
                                    input logic done);
    return (cur == PEND_W'(MAX_PEND)) && inc && !done;
  endfunction

  // A saturated counter holds rather than wrapping; the overflow flag records the lost pulse.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur, input logic inc,
                                                  input logic done);
    if (pend_sat(cur, inc, done)) return cur;
    return cur + PEND_W'(inc) - PEND_W'(done);
  endfunction

  assign rd_resp_ready = (count_q != CNT_W'(RD_FIFO_DEPTH));
  assign rsp_valid     = (count_q != '0);
  assign rsp_data      = data_mem[rd_ptr_q];
  assign rsp_id        = id_mem[rd_ptr_q];
  assign push          = rd_resp_valid && rd_resp_ready;
  assign pop           = rsp_valid && rsp_ready;

  // A done is held back only while the mapper issues the opposite type.
  assign read_done     = (pend_rd_q != '0) && (!mapper_valid || the_req_type == READ_TYPE);
  assign write_done    = (pend_wr_q != '0) && (!mapper_valid || the_req_type == WRITE_TYPE);
  assign pend_overflow = pend_overflow_q;

  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    pend_rd_d       = pend_next(pend_rd_q, pop, read_done);
    pend_wr_d       = pend_next(pend_wr_q, wr_ack_valid, write_done);
    pend_overflow_d = pend_overflow_q
                    | pend_sat(pend_rd_q, pop, read_done)
                    | pend_sat(pend_wr_q, wr_ack_valid, write_done);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      pend_rd_q       <= '0;
      pend_wr_q       <= '0;
      pend_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      pend_rd_q       <= pend_rd_d;
      pend_wr_q       <= pend_wr_d;
      pend_overflow_q <= pend_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= rd_resp_data;
      id_mem[wr_ptr_q]   <= rd_resp_id;
    end
  end

`ifdef DONE_STATS_EN
  logic [15:0] rd_retired_cnt_q, rd_retired_cnt_d;
  logic [15:0] wr_retired_cnt_q, wr_retired_cnt_d;

  always_comb begin
    rd_retired_cnt_d = rd_retired_cnt_q + 16'(read_done);
    wr_retired_cnt_d = wr_retired_cnt_q + 16'(write_done);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_retired_cnt_q <= '0;
      wr_retired_cnt_q <= '0;
    end else begin
      rd_retired_cnt_q <= rd_retired_cnt_d;
      wr_retired_cnt_q <= wr_retired_cnt_d;
    end
  end

  assign rd_retired_cnt = rd_retired_cnt_q;
  assign wr_retired_cnt = wr_retired_cnt_q;
`endif

endmodule

// File: tb/tb_txn_done_return.sv
// Directed bench for txn_done_return: FIFO ordering/backpressure, done-pulse deferral, saturation, reset.
module tb_txn_done_return;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [31:0] rd_resp_data;
  logic [7:0]  rd_resp_id;
  logic        wr_ack_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_id;
  logic        mapper_valid;
  logic        the_req_type;
  logic        read_done;
  logic        write_done;
  logic        pend_overflow;
`ifdef DONE_STATS_EN
  logic [15:0] rd_retired_cnt;
  logic [15:0] wr_retired_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int n_wd;

  always #5 clk = ~clk;

  txn_done_return dut (
    .clk           (clk),
    .rst           (rst),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .rd_resp_id    (rd_resp_id),
    .wr_ack_valid  (wr_ack_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .mapper_valid  (mapper_valid),
    .the_req_type  (the_req_type),
    .read_done     (read_done),
    .write_done    (write_done),
    .pend_overflow (pend_overflow)
`ifdef DONE_STATS_EN
    ,
    .rd_retired_cnt(rd_retired_cnt),
    .wr_retired_cnt(wr_retired_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0; rd_resp_id = '0;
    wr_ack_valid = 1'b0; rsp_ready = 1'b0; mapper_valid = 1'b0; the_req_type = 1'b0;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rd_ready", 32'(rd_resp_ready), 1);
    check("rst_read_done", 32'(read_done), 0);
    check("rst_write_done", 32'(write_done), 0);
    check("rst_overflow", 32'(pend_overflow), 0);
    rst = 1'b1;
    tick();

    // Three responses streamed straight through
    rsp_ready = 1'b1;
    rd_resp_valid = 1'b1; rd_resp_id = 8'd1; rd_resp_data = 32'hA1;
    tick();
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_id1", 32'(rsp_id), 1);
    check("t1_data1", rsp_data, 32'hA1);
    check("t1_rd0", 32'(read_done), 0);
    rd_resp_id = 8'd2; rd_resp_data = 32'hA2;
    tick();
    check("t1_id2", 32'(rsp_id), 2);
    check("t1_rd1", 32'(read_done), 1);
    rd_resp_id = 8'd3; rd_resp_data = 32'hA3;
    tick();
    check("t1_id3", 32'(rsp_id), 3);
    check("t1_data3", rsp_data, 32'hA3);
    check("t1_rd2", 32'(read_done), 1);
    rd_resp_valid = 1'b0;
    tick();
    check("t1_empty", 32'(rsp_valid), 0);
    check("t1_rd3", 32'(read_done), 1);
    check("t1_wd", 32'(write_done), 0);
    tick();
    check("t1_rd_end", 32'(read_done), 0);
`ifdef DONE_STATS_EN
    check("t1_rd_stats", 32'(rd_retired_cnt), 3);
    check("t1_wr_stats", 32'(wr_retired_cnt), 0);
`endif

    // Fill the FIFO under backpressure, then drain
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("t2_ready_fill", 32'(rd_resp_ready), 1);
      rd_resp_valid = 1'b1; rd_resp_id = 8'(16 + i); rd_resp_data = 32'hB00 + 32'(i);
      tick();
    end
    check("t2_full", 32'(rd_resp_ready), 0);
    check("t2_head", 32'(rsp_id), 16);
    rd_resp_id = 8'd99; rd_resp_data = 32'hDEAD;
    rsp_ready = 1'b1;
    tick();
    check("t2_ready_after_pop", 32'(rd_resp_ready), 1);
    check("t2_rd_after_pop", 32'(read_done), 1);
    rd_resp_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check("t2_valid", 32'(rsp_valid), 1);
      check("t2_id", 32'(rsp_id), 32'(16 + i));
      check("t2_data", rsp_data, 32'hB00 + 32'(i));
      tick();
    end
    check("t2_drained", 32'(rsp_valid), 0);
    check("t2_rd_tail", 32'(read_done), 1);
    tick();
    check("t2_rd_end", 32'(read_done), 0);

    // Write ack deferred while mapper issues reads
    mapper_valid = 1'b1; the_req_type = 1'b0; wr_ack_valid = 1'b1;
    tick();
    wr_ack_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_wd_blocked", 32'(write_done), 0);
      tick();
    end
    mapper_valid = 1'b0;
    #1;
    check("t3_wd_release", 32'(write_done), 1);
    tick();
    check("t3_wd_once", 32'(write_done), 0);

    // pend_rd=2, pend_wr=1, then release both
    mapper_valid = 1'b1; the_req_type = 1'b1;
    rd_resp_valid = 1'b1; rd_resp_id = 8'd40; rd_resp_data = 32'hC40;
    tick();
    check("t4_rd_a", 32'(read_done), 0);
    check("t4_wd_a", 32'(write_done), 0);
    rd_resp_id = 8'd41; rd_resp_data = 32'hC41;
    tick();
    check("t4_rd_b", 32'(read_done), 0);
    check("t4_id41", 32'(rsp_id), 41);
    rd_resp_valid = 1'b0; wr_ack_valid = 1'b1;
    check("t4_wd_b", 32'(write_done), 0);
    tick();
    wr_ack_valid = 1'b0; mapper_valid = 1'b0;
    #1;
    check("t4_c1_rd", 32'(read_done), 1);
    check("t4_c1_wd", 32'(write_done), 1);
    tick();
    check("t4_c2_rd", 32'(read_done), 1);
    check("t4_c2_wd", 32'(write_done), 0);
    tick();
    check("t4_c3_rd", 32'(read_done), 0);
    check("t4_c3_wd", 32'(write_done), 0);

    // Saturate pend_wr with 33 blocked acks
    mapper_valid = 1'b1; the_req_type = 1'b0; wr_ack_valid = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    check("t5_no_ovf_32", 32'(pend_overflow), 0);
    check("t5_wd_blocked", 32'(write_done), 0);
    tick();
    check("t5_ovf_33", 32'(pend_overflow), 1);
    wr_ack_valid = 1'b0; mapper_valid = 1'b0;
    #1;
    n_wd = 0;
    for (int i = 0; i < 40; i++) begin
      if (write_done) n_wd++;
      tick();
    end
    check("t5_wd_pulses", 32'(n_wd), 32);
    check("t5_ovf_sticky", 32'(pend_overflow), 1);

    // Reset with 5 buffered responses and pend_rd=3
    rsp_ready = 1'b0; mapper_valid = 1'b1; the_req_type = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_resp_valid = 1'b1; rd_resp_id = 8'(60 + i); rd_resp_data = 32'hD00 + 32'(i);
      tick();
    end
    rd_resp_valid = 1'b0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    rsp_ready = 1'b0;
    #1;
    check("t6_head", 32'(rsp_id), 63);
    check("t6_rd_blocked", 32'(read_done), 0);
    mapper_valid = 1'b0;
    #1;
    check("t6_rd_pending", 32'(read_done), 1);
    rst = 1'b0;
    tick();
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_read_done", 32'(read_done), 0);
    check("t6_write_done", 32'(write_done), 0);
    check("t6_rd_ready", 32'(rd_resp_ready), 1);
    check("t6_ovf_clr", 32'(pend_overflow), 0);
`ifdef DONE_STATS_EN
    check("t6_rd_stats", 32'(rd_retired_cnt), 0);
    check("t6_wr_stats", 32'(wr_retired_cnt), 0);
`endif
    rst = 1'b1;
    tick();
    check("t6_post_valid", 32'(rsp_valid), 0);
    check("t6_post_rd", 32'(read_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
